// File: rtl/decode_stage.sv
// decode_stage: RV32I decoder at the consumer end of the fetch-to-decode link.
// Each accepted {pc, instr} beat is decoded combinationally and captured into
// a two-entry skid buffer (main + skid). The main entry drives the micro-op
// outputs toward rename.
//
// Optional build macro DECODE_ILLEGAL_EN adds the `illegal` output. With it,
// malformed encodings are tagged and routed as fu_type=3 with no register
// side effects. Without it, unknown opcodes decode as a NOP.
//
// Handshake semantics (both sides): a beat transfers on a rising edge where
// valid and ready are both high. A producer holding valid must keep its
// payload stable until the transfer. ready_in depends only on registered
// state (skid occupancy), never combinationally on ready_out.
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mispredict,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [31:0]        instr_in,
  input  logic [XLEN-1:0]    pc_in,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [XLEN-1:0]    pc_out,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic               uses_rs1,
  output logic               uses_rs2,
  output logic               writes_rd,
  output logic [31:0]        imm,
  output logic [1:0]         fu_type,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               is_load,
  output logic               is_store,
  output logic [2:0]         mem_size
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic               illegal
`endif
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] FU_ALU    = 2'd0;
  localparam logic [1:0] FU_BRANCH = 2'd1;
  localparam logic [1:0] FU_LSU    = 2'd2;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SLL   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SRL   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SRA   = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_AUIPC = ALUOP_W'(11);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               writes_rd;
    logic [31:0]        imm;
    logic [1:0]         fu_type;
    logic [ALUOP_W-1:0] alu_op;
    logic               is_load;
    logic               is_store;
    logic [2:0]         mem_size;
`ifdef DECODE_ILLEGAL_EN
    logic               illegal;
`endif
  } uop_t;

  // Shared funct3 -> ALU op mapping; `alt` is instr[30] where it selects SUB/SRA.
  function automatic logic [ALUOP_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [ALUOP_W-1:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        wr_raw;
  uop_t        dec;
  uop_t        main_q, skid_q;
  logic        main_valid, skid_valid;
  logic        in_fire, out_fire;

  assign opcode = instr_in[6:0];
  assign f3     = instr_in[14:12];
  assign imm_i  = {{20{instr_in[31]}}, instr_in[31:20]};
  assign imm_s  = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b  = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                   instr_in[11:8], 1'b0};
  assign imm_u  = {instr_in[31:12], 12'b0};
  assign imm_j  = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                   instr_in[30:21], 1'b0};

`ifdef DECODE_ILLEGAL_EN
  logic bad;

  // Flag malformed encodings: unknown opcode, bad funct3 or bad funct7.
  always_comb begin
    bad = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_FENCE, OPC_SYSTEM: bad = 1'b0;
      OPC_LOAD:   bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      OPC_STORE:  bad = (f3 > 3'b010);
      OPC_BRANCH: bad = (f3 == 3'b010) || (f3 == 3'b011);
      OPC_OP: begin
        if (instr_in[31:25] == 7'b0000000)
          bad = 1'b0;
        else if (instr_in[31:25] == 7'b0100000)
          bad = !((f3 == 3'b000) || (f3 == 3'b101));
        else
          bad = 1'b1;
      end
      OPC_OPIMM: begin
        if (f3 == 3'b001)
          bad = (instr_in[31:25] != 7'b0000000);
        else if (f3 == 3'b101)
          bad = (instr_in[31:25] != 7'b0000000) && (instr_in[31:25] != 7'b0100000);
        else
          bad = 1'b0;
      end
      default: bad = 1'b1;
    endcase
    if (instr_in[1:0] != 2'b11) bad = 1'b1;
  end
`endif

  // Combinational RV32I decode of the incoming beat; default is a NOP.
  always_comb begin
    dec          = '0;
    wr_raw       = 1'b0;
    dec.pc       = pc_in;
    dec.rs1      = instr_in[19:15];
    dec.rs2      = instr_in[24:20];
    dec.rd       = instr_in[11:7];
    dec.fu_type  = FU_ALU;
    dec.alu_op   = ALU_ADD;
    case (opcode)
      OPC_LUI: begin
        wr_raw = 1'b1; dec.imm = imm_u; dec.alu_op = ALU_LUI;
      end
      OPC_AUIPC: begin
        wr_raw = 1'b1; dec.imm = imm_u; dec.alu_op = ALU_AUIPC;
      end
      OPC_JAL: begin
        wr_raw = 1'b1; dec.imm = imm_j; dec.fu_type = FU_BRANCH;
      end
      OPC_JALR: begin
        wr_raw = 1'b1; dec.uses_rs1 = 1'b1; dec.imm = imm_i; dec.fu_type = FU_BRANCH;
      end
      OPC_BRANCH: begin
        dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; dec.imm = imm_b;
        dec.fu_type  = FU_BRANCH; dec.alu_op = ALUOP_W'(f3);
      end
      OPC_LOAD: begin
        wr_raw = 1'b1; dec.uses_rs1 = 1'b1; dec.imm = imm_i; dec.fu_type = FU_LSU;
        dec.is_load = 1'b1; dec.mem_size = f3;
      end
      OPC_STORE: begin
        dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; dec.imm = imm_s; dec.fu_type = FU_LSU;
        dec.is_store = 1'b1; dec.mem_size = f3;
      end
      OPC_OPIMM: begin
        wr_raw = 1'b1; dec.uses_rs1 = 1'b1; dec.imm = imm_i;
        dec.alu_op = alu_from_f3(f3, (f3 == 3'b101) && instr_in[30]);
      end
      OPC_OP: begin
        wr_raw = 1'b1; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1;
        dec.alu_op = alu_from_f3(f3, instr_in[30]);
      end
      default: ;  // FENCE, SYSTEM and anything unrecognised: NOP
    endcase
    dec.writes_rd = wr_raw && (instr_in[11:7] != 5'd0);
`ifdef DECODE_ILLEGAL_EN
    dec.illegal = bad;
    if (bad) begin
      dec.uses_rs1  = 1'b0;
      dec.uses_rs2  = 1'b0;
      dec.writes_rd = 1'b0;
      dec.imm       = '0;
      dec.fu_type   = 2'd3;
      dec.alu_op    = ALU_ADD;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
      dec.mem_size  = 3'd0;
    end
`endif
  end

  assign ready_in  = !skid_valid;
  assign valid_out = main_valid;
  assign in_fire   = valid_in && ready_in;
  assign out_fire  = main_valid && ready_out;

  // Skid buffer update: reset and flush dominate, then refill/advance in order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (mispredict) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_fire && skid_valid) begin
      main_q     <= skid_q;
      main_valid <= 1'b1;
      skid_valid <= 1'b0;
    end else if (in_fire && (!main_valid || out_fire)) begin
      main_q     <= dec;
      main_valid <= 1'b1;
    end else if (in_fire) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end else if (out_fire) begin
      main_valid <= 1'b0;
    end
  end

  assign pc_out    = main_q.pc;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign rd        = main_q.rd;
  assign uses_rs1  = main_q.uses_rs1;
  assign uses_rs2  = main_q.uses_rs2;
  assign writes_rd = main_q.writes_rd;
  assign imm       = main_q.imm;
  assign fu_type   = main_q.fu_type;
  assign alu_op    = main_q.alu_op;
  assign is_load   = main_q.is_load;
  assign is_store  = main_q.is_store;
  assign mem_size  = main_q.mem_size;
`ifdef DECODE_ILLEGAL_EN
  assign illegal   = main_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed micro-op vectors with hand-computed expectations,
// a scoreboard queue filled at input handshakes and a monitor that pops on
// each output handshake.
module tb_decode_stage;

  localparam int W = 94;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mispredict;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] pc_out;
  logic [4:0]  rs1, rs2, rd;
  logic        uses_rs1, uses_rs2, writes_rd;
  logic [31:0] imm;
  logic [1:0]  fu_type;
  logic [3:0]  alu_op;
  logic        is_load, is_store;
  logic [2:0]  mem_size;
  logic        ill_bit;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act;

  // Clock: 10 time units, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .ALUOP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .mispredict(mispredict),
    .valid_in(valid_in), .ready_in(ready_in), .instr_in(instr_in), .pc_in(pc_in),
    .valid_out(valid_out), .ready_out(ready_out), .pc_out(pc_out),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .writes_rd(writes_rd),
    .imm(imm), .fu_type(fu_type), .alu_op(alu_op),
    .is_load(is_load), .is_store(is_store), .mem_size(mem_size)
`ifdef DECODE_ILLEGAL_EN
    , .illegal(ill_bit)
`endif
  );

`ifndef DECODE_ILLEGAL_EN
  assign ill_bit = 1'b0;
`endif

  assign act = {pc_out, rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, imm,
                fu_type, alu_op, is_load, is_store, mem_size, ill_bit};

  function automatic logic [W-1:0] mk(
    input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdi,
    input logic u1, input logic u2, input logic wr, input logic [31:0] im,
    input logic [1:0] fu, input logic [3:0] alu, input logic ld, input logic st,
    input logic [2:0] msz, input logic ill);
    return {pc, r1, r2, rdi, u1, u2, wr, im, fu, alu, ld, st, msz, ill};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Drive one beat, wait (bounded) for ready_in, record the expected micro-op.
  task automatic send_beat(input logic [31:0] pc, input logic [31:0] instr, input logic [W-1:0] e);
    int g = 0;
    @(negedge clk);
    valid_in = 1'b1;
    pc_in    = pc;
    instr_in = instr;
    while (!ready_in && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!ready_in) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: pc %h got ready_in=0, required 1", pc);
      valid_in = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  // One-cycle flush with a concurrent input beat that must never emerge.
  task automatic flush_with_beat(input logic [31:0] pc, input logic [31:0] instr);
    @(negedge clk);
    mispredict = 1'b1;
    valid_in   = 1'b1;
    pc_in      = pc;
    instr_in   = instr;
    @(posedge clk);
    #1;
    mispredict = 1'b0;
    valid_in   = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_valid_out", W'(valid_out), W'(1'b0));
    check("flush_ready_in", W'(ready_in), W'(1'b1));
  endtask

  task automatic wait_empty(input string name);
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check(name, W'(exp_q.size()), W'(0));
  endtask

  // Monitor: each output handshake pops and compares the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (reset_n && valid_out && ready_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL uop_unexpected: got %h, required no micro-op", act);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL uop[%0d]: got %h, required %h", n_out, act, e);
        end
      end
      n_out++;
    end
  end

  initial begin
    reset_n    = 1'b0;
    mispredict = 1'b0;
    valid_in   = 1'b0;
    instr_in   = '0;
    pc_in      = '0;
    ready_out  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_valid_out", W'(valid_out), W'(1'b0));
    check("reset_ready_in", W'(ready_in), W'(1'b1));
    check("reset_payload", act, '0);
    reset_n = 1'b1;

    // Basic decode stream with rename always ready.
    ready_out = 1'b1;
    send_beat(32'h0, 32'h00500093, mk(32'h0, 5'd0, 5'd5, 5'd1, 1, 0, 1, 32'd5, 2'd0, 4'd0, 0, 0, 3'd0, 0));
    check("latency_valid_out", W'(valid_out), W'(1'b1));
    send_beat(32'h4,  32'h0080A103, mk(32'h4,  5'd1,  5'd8,  5'd2,  1, 0, 1, 32'd8,         2'd2, 4'd0,  1, 0, 3'd2, 0));
    send_beat(32'h8,  32'hFE208CE3, mk(32'h8,  5'd1,  5'd2,  5'd25, 1, 1, 0, 32'hFFFFFFF8,  2'd1, 4'd0,  0, 0, 3'd0, 0));
    send_beat(32'hC,  32'h123452B7, mk(32'hC,  5'd8,  5'd3,  5'd5,  0, 0, 1, 32'h12345000,  2'd0, 4'd10, 0, 0, 3'd0, 0));
    send_beat(32'h10, 32'h00208033, mk(32'h10, 5'd1,  5'd2,  5'd0,  1, 1, 0, 32'd0,         2'd0, 4'd0,  0, 0, 3'd0, 0));
    send_beat(32'h14, 32'h402081B3, mk(32'h14, 5'd1,  5'd2,  5'd3,  1, 1, 1, 32'd0,         2'd0, 4'd1,  0, 0, 3'd0, 0));
    send_beat(32'h18, 32'h4030D213, mk(32'h18, 5'd1,  5'd3,  5'd4,  1, 0, 1, 32'h403,       2'd0, 4'd7,  0, 0, 3'd0, 0));
    send_beat(32'h1C, 32'hFE20AE23, mk(32'h1C, 5'd1,  5'd2,  5'd28, 1, 1, 0, 32'hFFFFFFFC,  2'd2, 4'd0,  0, 1, 3'd2, 0));
    send_beat(32'h20, 32'hFFDFF0EF, mk(32'h20, 5'd31, 5'd29, 5'd1,  0, 0, 1, 32'hFFFFFFFC,  2'd1, 4'd0,  0, 0, 3'd0, 0));
    send_beat(32'h24, 32'h00001397, mk(32'h24, 5'd0,  5'd0,  5'd7,  0, 0, 1, 32'h1000,      2'd0, 4'd11, 0, 0, 3'd0, 0));
`ifdef DECODE_ILLEGAL_EN
    send_beat(32'h28, 32'h00000000, mk(32'h28, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 2'd3, 4'd0, 0, 0, 3'd0, 1));
`else
    send_beat(32'h28, 32'h00000000, mk(32'h28, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 2'd0, 4'd0, 0, 0, 3'd0, 0));
`endif
    wait_empty("drain_stream");

    // Backpressure: three beats against a stalled rename, then release.
    ready_out = 1'b0;
    fork
      begin
        send_beat(32'h100, 32'hFFF14303, mk(32'h100, 5'd2, 5'd31, 5'd6,  1, 0, 1, 32'hFFFFFFFF, 2'd2, 4'd0, 1, 0, 3'd4, 0));
        send_beat(32'h104, 32'h00419863, mk(32'h104, 5'd3, 5'd4,  5'd16, 1, 1, 0, 32'd16,       2'd1, 4'd1, 0, 0, 3'd0, 0));
        send_beat(32'h108, 32'h0083E4B3, mk(32'h108, 5'd7, 5'd8,  5'd9,  1, 1, 1, 32'd0,        2'd0, 4'd8, 0, 0, 3'd0, 0));
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_ready_in_low", W'(ready_in), W'(1'b0));
        check("bp_valid_out", W'(valid_out), W'(1'b1));
        ready_out = 1'b1;
      end
    join
    wait_empty("drain_backpressure");

    // Flush with both entries occupied; concurrent beat is refused anyway.
    ready_out = 1'b0;
    send_beat(32'h200, 32'h00500093, mk(32'h200, 5'd0, 5'd5, 5'd1, 1, 0, 1, 32'd5, 2'd0, 4'd0, 0, 0, 3'd0, 0));
    send_beat(32'h204, 32'h0080A103, mk(32'h204, 5'd1, 5'd8, 5'd2, 1, 0, 1, 32'd8, 2'd2, 4'd0, 1, 0, 3'd2, 0));
    flush_with_beat(32'h208, 32'h402081B3);
    ready_out = 1'b1;
    repeat (3) @(negedge clk);
    check("flush2_idle", W'(valid_out), W'(1'b0));

    // Flush with one entry: the concurrent beat would be accepted but is dropped.
    ready_out = 1'b0;
    send_beat(32'h300, 32'h123452B7, mk(32'h300, 5'd8, 5'd3, 5'd5, 0, 0, 1, 32'h12345000, 2'd0, 4'd10, 0, 0, 3'd0, 0));
    flush_with_beat(32'h304, 32'h00500093);
    ready_out = 1'b1;
    repeat (3) @(negedge clk);
    check("flush1_idle", W'(valid_out), W'(1'b0));

    // Reset in the middle of a buffered stream.
    ready_out = 1'b0;
    send_beat(32'h400, 32'hFFDFF0EF, mk(32'h400, 5'd31, 5'd29, 5'd1, 0, 0, 1, 32'hFFFFFFFC, 2'd1, 4'd0, 0, 0, 3'd0, 0));
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midreset_valid_out", W'(valid_out), W'(1'b0));
    check("midreset_ready_in", W'(ready_in), W'(1'b1));
    check("midreset_payload", act, '0);

    // Recovery after reset.
    ready_out = 1'b1;
    send_beat(32'h500, 32'h00001397, mk(32'h500, 5'd0, 5'd0, 5'd7, 0, 0, 1, 32'h1000, 2'd0, 4'd11, 0, 0, 3'd0, 0));
    wait_empty("drain_final");
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
